mem_shadow_dump: RTL
====================

# mem_shadow_dump

Sequential read-out engine for the shadow port of an emulated memory: on command it walks a contiguous, wrapping address range, issues one read per word with fixed 1-cycle read latency, and streams the words out on a valid/ready interface with full backpressure support. It sits between the host-side scan/transport logic and the shadow read port that the mem_shadow pass attaches to each memory (inferred or sram instance), and is the reader counterpart of the design-side writers.

## Interface
- Depth, 256, number of words in the target memory (need not be a power of two)
- DataWidth, 8, word width in bits
- AddrWidth, $clog2(Depth), shadow address width (derived, not overridden)
- clk  in  1  sole clock
- rst_n  in  1  reset, asynchronous, active-low
- start_i  in  1  one-cycle command strobe; honoured only in IDLE
- base_i  in  AddrWidth  first address, sampled with start_i; must be < Depth
- count_i  in  AddrWidth+1  words to read, sampled with start_i; range 0..Depth
- busy_o  out  1  high from the cycle after an accepted start until done_o
- done_o  out  1  one-cycle pulse on completion
- mem_req_o  out  1  shadow read request
- mem_addr_o  out  AddrWidth  shadow read address
- mem_rdata_i  in  DataWidth  read data, valid exactly one cycle after mem_req_o
- out_valid_o  out  1  stream valid
- out_data_o  out  DataWidth  stream data
- out_last_o  out  1  marks final word of the dump
- out_ready_i  in  1  stream ready

## Operation
- States: IDLE, READ, DRAIN. Reset -> IDLE.
- IDLE: start_i with count_i > 0 -> READ, latch addr = base_i, remaining = count_i. start_i with count_i == 0 -> stay IDLE, pulse done_o next cycle, no stream output. start_i in READ/DRAIN ignored.
- READ: issue read (mem_req_o=1, mem_addr_o=addr) when remaining > 0 and (buffer occupancy + in-flight reads) < 2. Each issue: remaining-1; addr = (addr == Depth-1) ? 0 : addr+1. remaining reaches 0 -> DRAIN.
- Returning data written into a 2-entry output FIFO; in-flight read always has a free slot guaranteed by the issue rule. No data is ever dropped or duplicated.
- out_last_o asserted with the word corresponding to the final issued read (tracked by a last-flag carried alongside data).
- DRAIN: when the last word handshakes (out_valid_o & out_ready_i & out_last_o) -> IDLE, done_o pulses the following cycle, busy_o drops in that same cycle.
- mem_req_o low whenever no read is issued; mem_addr_o holds last value.

## Timing
- Reset values: busy_o=0, done_o=0, mem_req_o=0, mem_addr_o=0, out_valid_o=0, out_data_o=0, out_last_o=0.
- start_i sampled at edge E0; first mem_req_o in cycle after E0; data captured at following edge; first out_valid_o two cycles after first mem_req_o (3 cycles after start).
- With out_ready_i held high: one word per cycle sustained; N-word dump completes (done_o) N+3 cycles after start.
- out_valid_o/out_data_o/out_last_o stable while out_valid_o & !out_ready_i.
- Backpressure: at most 2 words buffered; issue stalls within one cycle of buffer filling.
- Wrap: Depth-1 followed by 0, including non-power-of-two Depth.
- rst_n asserted mid-dump: all state and FIFO cleared immediately, no done_o.

## Structure
- Package mem_shadow_pkg: state enum (IDLE, READ, DRAIN) and the buffer-entry struct (data + last flag), parameterised by DataWidth via a typedef in the module.
- Sub-module mem_shadow_skid: 2-entry FIFO with valid/ready on both sides, exposing occupancy for the issue rule.

## Test plan
- Depth=256, memory preloaded addr->addr^8'h5A; start base=0x10 count=4, ready high -> words 0x4A,0x4B,0x48,0x49, last on 4th, done_o at start+7.
- base=0xFE count=4 -> addresses FE,FF,00,01 issued in order; Depth=100 variant base=98 count=3 -> 98,99,0.
- count=0 -> no mem_req_o, no out_valid_o, done_o one cycle after start, busy_o stays 0.
- Random out_ready_i (50%) on count=256 -> all 256 words in order, exactly one last, never >2 reads outstanding+buffered.
- out_ready_i low for 10 cycles after first valid -> mem_req_o stops after 2 issues, data held stable, resumes on ready.
- start_i pulsed while busy -> ignored; rst_n low mid-dump -> outputs return to reset values, next start works normally.

Source files
------------

// File: rtl/mem_shadow_pkg.sv
// Shared types for the memory shadow read-out engine.
package mem_shadow_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain
    } state_e;

    localparam int unsigned SkidDepth = 2;

endpackage

// File: rtl/mem_shadow_skid.sv
// Two-entry FIFO between the shadow read port and the output stream.
module mem_shadow_skid
    import mem_shadow_pkg::*;
#(
    parameter int unsigned Width = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o,
    output logic [1:0]       occ_o
);

    logic [Width-1:0] mem_q [SkidDepth];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       occ_q, occ_d;
    logic             push, pop;

    always_comb begin
        in_ready_o  = (occ_q != 2'd2);
        out_valid_o = (occ_q != 2'd0);
        out_data_o  = mem_q[rd_ptr_q];
        occ_o       = occ_q;
        push        = in_valid_i & in_ready_o;
        pop         = out_valid_o & out_ready_i;
        wr_ptr_d    = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d    = pop ? ~rd_ptr_q : rd_ptr_q;
        occ_d       = occ_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data_i;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule

// File: rtl/mem_shadow_dump.sv
// Walks a wrapping address range on the shadow read port and streams the words out
// over valid/ready, with at most two words buffered or in flight.
module mem_shadow_dump
    import mem_shadow_pkg::*;
#(
    parameter int unsigned  Depth     = 256,
    parameter int unsigned  DataWidth = 8,
    localparam int unsigned AddrWidth = $clog2(Depth)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] base_i,
    input  logic [AddrWidth:0]   count_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 mem_req_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    input  logic [DataWidth-1:0] mem_rdata_i,
    output logic                 out_valid_o,
    output logic [DataWidth-1:0] out_data_o,
    output logic                 out_last_o,
    input  logic                 out_ready_i
);

    typedef struct packed {
        logic                 last;
        logic [DataWidth-1:0] data;
    } entry_t;

    localparam int unsigned          EntryWidth = $bits(entry_t);
    localparam logic [AddrWidth-1:0] LastAddr   = AddrWidth'(Depth - 1);
    localparam logic [AddrWidth-1:0] AddrOne    = 1;
    localparam logic [AddrWidth:0]   CntOne     = 1;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [AddrWidth-1:0] hold_addr_q, hold_addr_d;
    logic [AddrWidth:0]   remaining_q, remaining_d;
    logic                 inflight_q, inflight_last_q;
    logic                 done_q, done_d;
    logic                 issue;
    logic [2:0]           load;
    entry_t               push_entry, head_entry;
    logic                 fifo_valid, fifo_pop, fifo_in_ready;
    logic [1:0]           fifo_occ;

    // A word leaving the FIFO this cycle frees its slot before the new read's data lands.
    always_comb begin
        fifo_pop   = fifo_valid & out_ready_i;
        load       = {1'b0, fifo_occ} + {2'b00, inflight_q} - {2'b00, fifo_pop};
        issue      = (state_q == StRead) && (remaining_q != '0) && (load < 3'd2);
        push_entry = '{last: inflight_last_q, data: mem_rdata_i};
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        hold_addr_d = hold_addr_q;
        done_d      = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (count_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = StRead;
                        addr_d      = base_i;
                        remaining_d = count_i;
                    end
                end
            end
            StRead: begin
                if (issue) begin
                    remaining_d = remaining_q - CntOne;
                    addr_d      = (addr_q == LastAddr) ? '0 : addr_q + AddrOne;
                    hold_addr_d = addr_q;
                    if (remaining_q == CntOne) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (fifo_pop && head_entry.last) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o      = (state_q != StIdle);
        done_o      = done_q;
        mem_req_o   = issue;
        mem_addr_o  = issue ? addr_q : hold_addr_q;
        out_valid_o = fifo_valid;
        out_data_o  = head_entry.data;
        out_last_o  = head_entry.last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            hold_addr_q     <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            hold_addr_q     <= hold_addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && (remaining_q == CntOne);
            done_q          <= done_d;
        end
    end

    mem_shadow_skid #(
        .Width(EntryWidth)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (inflight_q),
        .in_ready_o (fifo_in_ready),
        .in_data_i  (push_entry),
        .out_valid_o(fifo_valid),
        .out_ready_i(out_ready_i),
        .out_data_o (head_entry),
        .occ_o      (fifo_occ)
    );

    // The issue rule must always leave room for returning read data.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        inflight_q |-> fifo_in_ready);

endmodule
